// File: rtl/microprocesador_legion_param.sv
`default_nettype none
// ============================================================================
// Module   : microprocesador_legion_param
// Brief    : Parametrised multi-cycle Legion register machine (FETCH/EXEC/MEM/HALT)
//            stepping on work-frequency ticks. Optional: LEGION_ESPERA_EN (i_Listo wait).
// Revision : 1.0 - initial release
// ============================================================================
module microprocesador_legion_param #(
    parameter int  DATA_W  = 8,
    parameter int  ADDR_W  = 8,
    parameter int  SEL_W   = 3,
    localparam int INSTR_W = 3 + 2 * SEL_W
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic [INSTR_W-1:0] i_Instrucciones,
    input  logic [DATA_W-1:0]  i_Bus_Datos,
    input  logic [31:0]        i_Frec_de_trabajo,
    output logic [ADDR_W-1:0]  o_Direcciones_Instrucciones,
    output logic [ADDR_W-1:0]  o_Direcciones_Datos,
    output logic [DATA_W-1:0]  o_Bus_Datos,
    output logic               o_Lectura_Escritura,
    output logic               o_Halt
`ifdef LEGION_ESPERA_EN
    ,
    input  logic               i_Listo
`endif
);

    localparam int NREG = 2 ** SEL_W;

    localparam logic [1:0] c_FETCH = 2'd0;
    localparam logic [1:0] c_EXEC  = 2'd1;
    localparam logic [1:0] c_MEM   = 2'd2;
    localparam logic [1:0] c_HALT  = 2'd3;

    localparam logic [2:0] c_OP_LDM  = 3'b000;
    localparam logic [2:0] c_OP_LDI  = 3'b001;
    localparam logic [2:0] c_OP_STM  = 3'b010;
    localparam logic [2:0] c_OP_SUB  = 3'b011;
    localparam logic [2:0] c_OP_MOV  = 3'b100;
    localparam logic [2:0] c_OP_ADD  = 3'b101;
    localparam logic [2:0] c_OP_JMP  = 3'b110;
    localparam logic [2:0] c_OP_HALT = 3'b111;

    logic [31:0]        r_div;
    logic [31:0]        w_div_last;
    logic               w_tick;
    logic               w_mem_done;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;

    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [DATA_W-1:0]  r_regs [NREG];
    logic               r_z;
    logic               r_c;
    logic [ADDR_W-1:0]  r_daddr;
    logic [DATA_W-1:0]  r_dout;
    logic               r_is_store;

    logic [2:0]         w_op;
    logic [SEL_W-1:0]   w_a;
    logic [SEL_W-1:0]   w_b;
    logic [2:0]         w_jf;
    logic [DATA_W-1:0]  w_ra;
    logic [DATA_W-1:0]  w_rb;
    logic [DATA_W:0]    w_sum;
    logic [DATA_W:0]    w_dif;
    logic               w_taken;

    // N of 0 or 1 both mean "step every clock"; >= keeps a lowered N from stalling
    assign w_div_last = (i_Frec_de_trabajo == 32'd0) ? 32'd0 : i_Frec_de_trabajo - 32'd1;
    assign w_tick     = (r_div >= w_div_last);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_div <= 32'd0;
        end else if (w_tick) begin
            r_div <= 32'd0;
        end else begin
            r_div <= r_div + 32'd1;
        end
    end

`ifdef LEGION_ESPERA_EN
    assign w_mem_done = i_Listo;
`else
    assign w_mem_done = 1'b1;
`endif

    assign w_op = r_ir[INSTR_W-1 -: 3];
    assign w_a  = r_ir[2*SEL_W-1 -: SEL_W];
    assign w_b  = r_ir[SEL_W-1:0];
    assign w_ra = r_regs[w_a];
    assign w_rb = r_regs[w_b];

    // Jump condition/link bits; narrow select fields read the missing bits as 0
    generate
        if (SEL_W >= 3) begin : g_jf_full
            assign w_jf = w_b[2:0];
        end else begin : g_jf_pad
            assign w_jf = {{(3 - SEL_W){1'b0}}, w_b};
        end
    endgenerate

    assign w_sum = {1'b0, w_ra} + {1'b0, w_rb};
    assign w_dif = {1'b0, w_ra} - {1'b0, w_rb};

    always_comb begin
        w_taken = 1'b0;
        case (w_jf[2:1])
            2'b00:   w_taken = 1'b1;
            2'b01:   w_taken = r_z;
            2'b10:   w_taken = r_c;
            default: w_taken = ~r_z;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_tick) begin
            case (r_state)
                c_FETCH: w_state_next = c_EXEC;
                c_EXEC: begin
                    if (w_op == c_OP_LDM || w_op == c_OP_STM) begin
                        w_state_next = c_MEM;
                    end else if (w_op == c_OP_HALT) begin
                        w_state_next = c_HALT;
                    end else begin
                        w_state_next = c_FETCH;
                    end
                end
                c_MEM: begin
                    if (w_mem_done) begin
                        w_state_next = c_FETCH;
                    end
                end
                default: w_state_next = c_HALT;
            endcase
        end
    end

    always_comb begin
        o_Halt              = (r_state == c_HALT);
        o_Lectura_Escritura = (r_state == c_MEM) && r_is_store;
    end

    assign o_Direcciones_Instrucciones = r_pc;
    assign o_Direcciones_Datos         = r_daddr;
    assign o_Bus_Datos                 = r_dout;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_pc       <= '0;
            r_ir       <= '0;
            r_z        <= 1'b0;
            r_c        <= 1'b0;
            r_daddr    <= '0;
            r_dout     <= '0;
            r_is_store <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_tick) begin
            case (r_state)
                c_FETCH: begin
                    r_ir <= i_Instrucciones;
                    r_pc <= r_pc + ADDR_W'(1);
                end
                c_EXEC: begin
                    case (w_op)
                        c_OP_LDM: begin
                            r_daddr    <= ADDR_W'(w_rb);
                            r_is_store <= 1'b0;
                        end
                        c_OP_LDI: r_regs[w_a] <= DATA_W'(w_b);
                        c_OP_STM: begin
                            r_daddr    <= ADDR_W'(w_ra);
                            r_dout     <= w_rb;
                            r_is_store <= 1'b1;
                        end
                        c_OP_SUB: begin
                            {r_c, r_regs[w_a]} <= w_dif;
                            r_z                <= (w_dif[DATA_W-1:0] == '0);
                        end
                        c_OP_MOV: r_regs[w_a] <= w_rb;
                        c_OP_ADD: begin
                            {r_c, r_regs[w_a]} <= w_sum;
                            r_z                <= (w_sum[DATA_W-1:0] == '0);
                        end
                        c_OP_JMP: begin
                            // Target is sampled before the link write, so a==NREG-1 still jumps to the old value
                            if (w_taken) begin
                                r_pc <= ADDR_W'(w_ra);
                                if (w_jf[0]) begin
                                    r_regs[NREG-1] <= DATA_W'(r_pc);
                                end
                            end
                        end
                        default: ;
                    endcase
                end
                c_MEM: begin
                    if (w_mem_done && !r_is_store) begin
                        r_regs[w_a] <= i_Bus_Datos;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/microprocesador_legion_param.md
Name: microprocesador_legion_param

Overview:
Parametrised successor of the Legion core: a multi-cycle accumulator-free register machine with separate instruction and data address buses. Generalised data/address width and register-file depth, plus flags, conditional/linked jumps, HALT and an explicit FETCH/EXEC/MEM state machine. The core advances only on work-frequency ticks derived from i_Frec_de_trabajo. It sits between instruction ROM and data RAM in the Legion SoC top.

Parameters:
DATA_W, 8, register/data-bus width
ADDR_W, 8, instruction and data address width
SEL_W, 3, register-select field width; register count NREG = 2**SEL_W
INSTR_W, 3+2*SEL_W, instruction width (derived, not overridden)

Ports:
i_Clk  input  1  clock; all state on rising edge
i_Rst  input  1  synchronous, active-high reset
i_Instrucciones  input  INSTR_W  instruction word at o_Direcciones_Instrucciones
i_Bus_Datos  input  DATA_W  read data from data memory
i_Frec_de_trabajo  input  32  tick divider: one core step every max(N,1) clocks
o_Direcciones_Instrucciones  output  ADDR_W  PC
o_Direcciones_Datos  output  ADDR_W  data address
o_Bus_Datos  output  DATA_W  write data
o_Lectura_Escritura  output  1  1=write strobe, 0=read
o_Halt  output  1  core halted

Behaviour:
- One clock, reset synchronous active-high. Reset: PC=0, all registers=0, Z=C=0, state=FETCH, divider=0, all outputs 0. Reset mid-MEM aborts access; write strobe low after that edge.
- Tick: divider counts 0..max(N,1)-1; tick on final count, then wraps to 0. N=0 or 1 -> tick every clock. FSM and registers change only on tick edges; outputs hold between ticks.
- Encoding: op=IR[INSTR_W-1 -: 3], a=IR[2*SEL_W-1 -: SEL_W], b=IR[SEL_W-1:0].
- FETCH (tick): IR<=i_Instrucciones; PC<=PC+1 mod 2**ADDR_W; ->EXEC.
- EXEC (tick), by op:
  000 LDM: o_Direcciones_Datos<=R[b]; ->MEM.
  001 LDI: R[a]<=zero-extended b; ->FETCH.
  010 STM: o_Direcciones_Datos<=R[a], o_Bus_Datos<=R[b]; ->MEM.
  011 SUB: {C,R[a]}<=R[a]-R[b] (C=borrow); Z<=(result==0); ->FETCH.
  100 MOV: R[a]<=R[b]; flags unchanged; ->FETCH.
  101 ADD: {C,R[a]}<=R[a]+R[b], DATA_W+1-bit sum; Z<=(R[a] result==0); ->FETCH.
  110 JMP: cond=b[2:1] (00 always,01 Z,10 C,11 !Z). If taken: PC<=R[a] (truncated/zero-extended to ADDR_W); if b[0], R[NREG-1]<=PC (already incremented, zero-extended). If a==NREG-1 with link, target read before link write. Not taken: no change. ->FETCH.
  111 HALT: ->HALT.
- SEL_W<3: cond/link use available b bits; missing bits read 0.
- MEM (tick): LDM: R[a]<=i_Bus_Datos, strobe 0. STM: o_Lectura_Escritura=1 for whole MEM state, memory captures on leaving tick; strobe 0 on return to FETCH. ->FETCH.
- HALT: o_Halt=1; no state change until reset; divider keeps running.
- Address/data outputs other than strobe retain last value outside MEM.

Optional Feature:
LEGION_ESPERA_EN: adds port i_Listo (input,1). In MEM, state exits only on a tick with i_Listo=1; otherwise remains in MEM with address, data and strobe held. Without macro: no port; MEM always lasts exactly one tick.

Test Plan:
- Reset: N=1, i_Rst high 2 clocks then low -> all outputs 0; first tick drives PC=0, PC=1 after FETCH.
- LDI R1,5; LDI R2,3; ADD R1,R2 -> R1=8, Z=0, C=0; LDI R3,0; SUB R3,R3 -> Z=1.
- Overflow: R1=0xFF via LDM (i_Bus_Datos=8'hFF), LDI R2,1, ADD R1,R2 -> R1=0x00, C=1, Z=1.
- STM R4,R5 with R4=0x20,R5=0x3C -> during MEM: o_Direcciones_Datos=0x20, o_Bus_Datos=0x3C, o_Lectura_Escritura=1 for one tick only.
- JMP R6 with link (b=001) at PC=0x10, R6=0x40 -> next fetch address 0x40, R7=0x11; JMP cond Z with Z=0 -> next fetch 0x11.
- N=4: one state step every 4 clocks; HALT -> o_Halt=1, PC frozen 20 clocks; with LEGION_ESPERA_EN, i_Listo=0 for 3 ticks holds STM strobe high 4 ticks.
